// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin arbiter sharing one combinational ALU between two requesters,
// holding registered operands for ALU_WAIT cycles before capturing the result.
module alu_share_sched #(
    parameter int WIDTH    = 16,
    parameter int ALU_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_opc0,
    input  logic [2:0]       req_opc1,
    input  logic [WIDTH-1:0] req_m0,
    input  logic [WIDTH-1:0] req_m1,
    input  logic [WIDTH-1:0] req_n0,
    input  logic [WIDTH-1:0] req_n1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zer,
    output logic             rsp_neg,
    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_m,
    output logic [WIDTH-1:0] alu_n,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic gnt_q, gnt_d, last_q, last_d, win;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] opc_q, opc_d;
    logic [WIDTH-1:0] m_q, m_d, n_q, n_d, data_q, data_d;
    logic zer_q, zer_d, neg_q, neg_d;
    always_comb begin
        win = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        state_d = state_q;
        gnt_d = gnt_q;
        last_d = last_q;
        cnt_d = cnt_q;
        opc_d = opc_q;
        m_d = m_q;
        n_d = n_q;
        data_d = data_q;
        zer_d = zer_q;
        neg_d = neg_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                // ready is masked during reset so nothing appears accepted while rst is held
                req_ready = (!rst && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
                if (|req_valid) begin
                    state_d = EXEC;
                    gnt_d = win;
                    cnt_d = 4'(ALU_WAIT - 1);
                    opc_d = win ? req_opc1 : req_opc0;
                    m_d = win ? req_m1 : req_m0;
                    n_d = win ? req_n1 : req_n0;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    data_d = alu_f;
                    zer_d = alu_zer;
                    neg_d = alu_neg;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = gnt_q ? 2'b10 : 2'b01;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                    last_d = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= 1'b0;
            last_q <= 1'b1;
            cnt_q <= 4'd0;
            opc_q <= 3'd0;
            m_q <= '0;
            n_q <= '0;
            data_q <= '0;
            zer_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            opc_q <= opc_d;
            m_q <= m_d;
            n_q <= n_d;
            data_q <= data_d;
            zer_q <= zer_d;
            neg_q <= neg_d;
        end
    end
    assign alu_opc = opc_q;
    assign alu_m = m_q;
    assign alu_n = n_q;
    assign rsp_data = data_q;
    assign rsp_zer = zer_q;
    assign rsp_neg = neg_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: directed tables, hand sequences and a randomized run checked
// against a transaction-level model; a second instance covers ALU_WAIT=4.
module tb_alu_share_sched;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req_valid = 2'b00, rsp_ready = 2'b00;
    logic [2:0] req_opc0 = 3'd0, req_opc1 = 3'd0;
    logic [15:0] req_m0 = '0, req_m1 = '0, req_n0 = '0, req_n1 = '0;
    logic [1:0] rr1, rv1, rr4, rv4;
    logic [15:0] rd1, am1, an1, f1, rd4, am4, an4, f4, pert;
    logic [2:0] ao1, ao4;
    logic rz1, rn1, b1, rz4, rn4, b4;
    int pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    assign f1 = am1 + an1;
    assign f4 = am4 + an4 + pert;

    alu_share_sched #(.WIDTH(16), .ALU_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1),
        .req_opc0(req_opc0), .req_opc1(req_opc1), .req_m0(req_m0), .req_m1(req_m1),
        .req_n0(req_n0), .req_n1(req_n1), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_data(rd1), .rsp_zer(rz1), .rsp_neg(rn1), .alu_opc(ao1), .alu_m(am1),
        .alu_n(an1), .alu_f(f1), .alu_zer(f1 == 16'd0), .alu_neg(f1[15]), .busy(b1));

    alu_share_sched #(.WIDTH(16), .ALU_WAIT(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr4),
        .req_opc0(req_opc0), .req_opc1(req_opc1), .req_m0(req_m0), .req_m1(req_m1),
        .req_n0(req_n0), .req_n1(req_n1), .rsp_valid(rv4), .rsp_ready(rsp_ready),
        .rsp_data(rd4), .rsp_zer(rz4), .rsp_neg(rn4), .alu_opc(ao4), .alu_m(am4),
        .alu_n(an4), .alu_f(f4), .alu_zer(f4 == 16'd0), .alu_neg(f4[15]), .busy(b4));

    typedef struct {
        logic [1:0] rv;
        logic [1:0] exp_rr;
        logic [1:0] exp_rsp;
        logic [15:0] exp_data;
        logic exp_neg;
        logic exp_busy;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    function automatic int pick(input logic [1:0] v, input int last);
        return (v == 2'b11) ? 1 - last : (v[1] ? 1 : 0);
    endfunction

    // random-run state: requester queues of one op each, plus the model's view of the shared ALU
    logic pend[2];
    logic [15:0] rm[2], rn[2];
    logic [2:0] ro[2];
    int owner, wait_left, mlast, w;
    logic [15:0] cap_f;
    logic [1:0] exp_rr, exp_rv;

    initial begin
        pert = '0;
        vecs[0]  = '{2'b11, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 2'b00, 2'b01, 16'h0002, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, 2'b10, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 2'b00, 2'b10, 16'h8000, 1'b1, 1'b1};
        vecs[6]  = '{2'b11, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{2'b11, 2'b00, 2'b01, 16'h0002, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 2'b10, 2'b00, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{2'b11, 2'b00, 2'b10, 16'h8000, 1'b1, 1'b1};

        // reset values while rst is held
        #1;
        chk("rst_busy", b1, 0);
        chk("rst_rsp_valid", rv1, 0);
        chk("rst_alu_m", am1, 0);
        chk("rst_alu_n", an1, 0);
        chk("rst_alu_opc", ao1, 0);
        chk("rst_rsp_data", rd1, 0);
        chk("rst_flags", {rz1, rn1}, 0);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", rr1, 0);
        req_valid = 2'b00;
        #1;
        rst = 1'b0;

        // single op, ALU_WAIT=1
        cyc();
        req_valid = 2'b01; req_m0 = 16'd5; req_n0 = 16'd3; req_opc0 = 3'b100; rsp_ready = 2'b11;
        #1;
        chk("single_req_ready", rr1, 2'b01);
        chk("single_idle_busy", b1, 0);
        cyc();
        req_valid = 2'b00;
        chk("single_alu_m", am1, 5);
        chk("single_alu_n", an1, 3);
        chk("single_alu_opc", ao1, 3'b100);
        chk("single_exec_busy", b1, 1);
        chk("single_exec_rsp", rv1, 0);
        cyc();
        chk("single_rsp_valid", rv1, 2'b01);
        chk("single_rsp_data", rd1, 8);
        chk("single_rsp_flags", {rz1, rn1}, 0);
        chk("single_resp_busy", b1, 1);
        cyc();
        chk("single_done_busy", b1, 0);
        chk("single_done_rsp", rv1, 0);
        chk("single_alu_m_kept", am1, 5);

        // fair alternation table, both requesters always asking
        do_reset();
        req_m0 = 16'd1; req_n0 = 16'd1; req_m1 = 16'h7FFF; req_n1 = 16'd1; rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            req_valid = vecs[i].rv;
            #1;
            chk($sformatf("fair%0d_req_ready", i), rr1, vecs[i].exp_rr);
            chk($sformatf("fair%0d_rsp_valid", i), rv1, vecs[i].exp_rsp);
            chk($sformatf("fair%0d_busy", i), b1, vecs[i].exp_busy);
            if (vecs[i].exp_rsp != 2'b00) begin
                chk($sformatf("fair%0d_data", i), rd1, vecs[i].exp_data);
                chk($sformatf("fair%0d_neg", i), rn1, vecs[i].exp_neg);
            end
            cyc();
        end

        // zero result under long backpressure; non-granted rsp_ready must be ignored
        do_reset();
        req_valid = 2'b10; req_m1 = 16'hFFFF; req_n1 = 16'd1; req_m0 = 16'd9; req_n0 = 16'd9;
        #1;
        chk("bp_req_ready", rr1, 2'b10);
        cyc();
        req_valid = 2'b01;
        cyc();
        for (int i = 0; i < 10; i++) begin
            rsp_ready = (i < 5) ? 2'b00 : 2'b01;
            #1;
            chk($sformatf("bp%0d_rsp_valid", i), rv1, 2'b10);
            chk($sformatf("bp%0d_data", i), rd1, 0);
            chk($sformatf("bp%0d_zer", i), rz1, 1);
            chk($sformatf("bp%0d_req_ready", i), rr1, 0);
            cyc();
        end
        rsp_ready = 2'b10;
        #1;
        chk("bp_release_valid", rv1, 2'b10);
        cyc();
        chk("bp_after_rsp", rv1, 0);
        chk("bp_next_winner", rr1, 2'b01);
        req_valid = 2'b00;

        // ALU_WAIT=4 on dut4: late changes to the ALU output must be what gets captured
        do_reset();
        req_valid = 2'b01; req_m0 = 16'd10; req_n0 = 16'd20; rsp_ready = 2'b11;
        #1;
        chk("w4_req_ready", rr4, 2'b01);
        cyc();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) pert = 16'h0005;
            if (i == 3) pert = 16'h0100;
            #1;
            chk($sformatf("w4_exec%0d_m", i), am4, 10);
            chk($sformatf("w4_exec%0d_n", i), an4, 20);
            chk($sformatf("w4_exec%0d_rsp", i), rv4, 0);
            chk($sformatf("w4_exec%0d_busy", i), b4, 1);
            cyc();
        end
        chk("w4_rsp_valid", rv4, 2'b01);
        chk("w4_rsp_data", rd4, 16'h011E);
        pert = '0;

        // async reset mid-EXEC
        do_reset();
        req_valid = 2'b11; req_m0 = 16'd40; req_n0 = 16'd2; req_m1 = 16'd7; req_n1 = 16'd7;
        cyc();
        chk("ar_exec_busy", b1, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_exec_busy_drop", b1, 0);
        chk("ar_exec_ready_drop", rr1, 0);
        chk("ar_exec_rsp_drop", rv1, 0);
        rst = 1'b0;
        #1;
        chk("ar_exec_r0_first", rr1, 2'b01);
        cyc();
        cyc();
        chk("ar_resp_valid", rv1, 2'b01);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_resp_rsp_drop", rv1, 0);
        chk("ar_resp_busy_drop", b1, 0);
        chk("ar_resp_ready_drop", rr1, 0);
        rst = 1'b0;
        #1;
        chk("ar_resp_r0_first", rr1, 2'b01);
        rsp_ready = 2'b11;
        cyc();
        req_valid = 2'b10;
        chk("ar_no_stale_rsp", rv1, 0);
        cyc();
        chk("ar_new_rsp_valid", rv1, 2'b01);
        chk("ar_new_rsp_data", rd1, 42);
        req_valid = 2'b00;

        // randomized traffic against a transaction-level model
        do_reset();
        cyc();
        pend[0] = 0; pend[1] = 0;
        owner = -1; wait_left = 0; mlast = 1; cap_f = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k] = 1;
                    rm[k] = 16'($urandom);
                    rn[k] = ($urandom_range(0, 3) == 0) ? 16'(16'd0 - rm[k]) : 16'($urandom);
                    ro[k] = 3'($urandom);
                end
            end
            req_valid = {pend[1], pend[0]};
            req_m0 = rm[0]; req_n0 = rn[0]; req_opc0 = ro[0];
            req_m1 = rm[1]; req_n1 = rn[1]; req_opc1 = ro[1];
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            exp_rr = 2'b00;
            exp_rv = 2'b00;
            if (owner < 0 && req_valid != 2'b00) exp_rr = 2'b01 << pick(req_valid, mlast);
            if (owner >= 0 && wait_left == 0) exp_rv = 2'b01 << owner;
            chk("rnd_req_ready", rr1, exp_rr);
            chk("rnd_rsp_valid", rv1, exp_rv);
            chk("rnd_busy", b1, owner >= 0);
            if (exp_rv != 2'b00) begin
                chk("rnd_data", rd1, cap_f);
                chk("rnd_zer", rz1, cap_f == 16'd0);
                chk("rnd_neg", rn1, cap_f[15]);
            end
            if (owner < 0 && req_valid != 2'b00) begin
                w = pick(req_valid, mlast);
                owner = w;
                wait_left = 1;
                cap_f = rm[w] + rn[w];
                pend[w] = 0;
            end else if (owner >= 0 && wait_left > 0) begin
                wait_left--;
            end else if (owner >= 0 && rsp_ready[owner]) begin
                mlast = owner;
                owner = -1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
- Round-robin scheduler that shares one 16-bit combinational ALU (3-bit opcode, 16-bit M/N operands, F result, zero/negative flags) between two requesters.
- Accepts one operation at a time and drives registered operands and opcode to the ALU.
- Waits a configurable number of settle cycles, then captures F/zer/neg.
- Returns the result on the winning requester's response channel with a valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- ALU_WAIT, 1, cycles operands are held before F is sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit k = requester k
- req_ready  out  2  per-requester request ready
- req_opc0 / req_opc1  in  3 each  opcode from requester 0 / 1
- req_m0 / req_m1  in  WIDTH each  M operand
- req_n0 / req_n1  in  WIDTH each  N operand
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response ready
- rsp_data  out  WIDTH  captured F; meaningful only for the requester whose rsp_valid bit is set
- rsp_zer  out  1  captured zero flag
- rsp_neg  out  1  captured negative flag
- alu_opc  out  3  registered opcode to ALU
- alu_m  out  WIDTH  registered M to ALU
- alu_n  out  WIDTH  registered N to ALU
- alu_f  in  WIDTH  ALU result
- alu_zer  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Registers: gnt (1b, owner of current op), last (1b, last served), cnt (4b), result regs.
- Reset (async, rst=1), all forced immediately:
  - state=IDLE, last=1, so requester 0 wins the first tie.
  - gnt=0, cnt=0.
  - alu_opc=0, alu_m=0, alu_n=0.
  - rsp_data=0, rsp_zer=0, rsp_neg=0, rsp_valid=2'b00, busy=0.
  - Any in-flight operation is discarded; no response is ever produced for it.
- Arbitration, IDLE only, combinational:
  - If exactly one req_valid bit is set, that requester wins.
  - If both are set, winner = ~last.
  - req_ready is one-hot on the winner in IDLE, 2'b00 in every other state.
  - req_ready never depends on rsp_ready.
- IDLE -> EXEC on handshake (req_valid[w] & req_ready[w]):
  - Capture the winner's opc/m/n into alu_opc/alu_m/alu_n.
  - gnt<=w, cnt<=ALU_WAIT-1.
  - The non-winner is untouched and must keep its request asserted.
- EXEC:
  - alu_* hold constant.
  - When cnt==0: rsp_data<=alu_f, rsp_zer<=alu_zer, rsp_neg<=alu_neg; state<=RESP.
  - Otherwise cnt decrements.
  - EXEC lasts exactly ALU_WAIT cycles.
- RESP:
  - rsp_valid[gnt]=1, other bit 0. rsp_data/zer/neg stable while valid.
  - On rsp_ready[gnt]: state<=IDLE, last<=gnt.
  - rsp_ready of the non-granted requester is ignored.
  - Backpressure of any length is held indefinitely.
- Latency, with ALU_WAIT=1 and rsp_ready held high:
  - Accept at edge 0; result captured at edge 1; rsp_valid visible after edge 1.
  - Response handshake at edge 2; next accept possible at edge 3.
  - Throughput: one op per ALU_WAIT+2 cycles.
- alu_opc/alu_m/alu_n keep their last values in RESP and IDLE until the next accept; they are not cleared.
- Flags are sampled from the ALU, never recomputed locally.
- WIDTH arithmetic is owned by the ALU; this block performs no arithmetic except cnt.

Test Plan:
- Bench ALU stub for all scenarios: F=M+N mod 2^16, zer=(F==0), neg=F[15].
- Reset then single op: req_valid=01, m0=5, n0=3, opc0=100, rsp_ready=11 -> req_ready=01 in accept cycle; alu_m=5, alu_n=3, alu_opc=100 after accept; rsp_valid=01 with rsp_data=8, zer=0, neg=0 one cycle after accept (ALU_WAIT=1); busy high from accept edge until response handshake.
- Simultaneous requests from reset, both held: r0 (m=1, n=1), r1 (m=16'h7FFF, n=1) -> r0 served first (data 2, rsp_valid=01); then r1 served (data 16'h8000, neg=1, rsp_valid=10); then r0 again (fair alternation over 4 ops).
- Zero result and backpressure: m1=16'hFFFF, n1=1, rsp_ready=00 for 10 cycles -> rsp_valid=10, data=0, zer=1, held stable 10 cycles; req_ready=00 throughout; released on rsp_ready=10.
- ALU_WAIT=4: single request -> alu_m/n constant 4 cycles; rsp_valid rises exactly 4 cycles after accept edge; stub output changed mid-EXEC is not captured until the final EXEC cycle.
- Async reset mid-EXEC and mid-RESP: assert rst between clock edges -> rsp_valid, busy, req_ready drop immediately; after release, both requesting gives requester 0 first; the aborted op produces no response.
